// File: rtl/ifu_npc.sv
// Next-PC unit for the fetch stage: selects the next fetch address and checks that it is legal.
// An illegal target stops fetch and raises fault until the next reset.
module ifu_npc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] IM_LAST = IM_BASE + (32'(IM_WORDS) << 2) - 32'd4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic        fault_r, fault_nxt_s;
  logic [31:0] cand_s;
  logic [31:0] br_off_s;
  logic        legal_s;

  // Word-aligned and inside the instruction memory window.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IM_BASE) && (a <= IM_LAST);
  endfunction

  assign pc_plus4 = pc_r + 32'd4;
  assign pc_plus8 = pc_r + 32'd8;
  assign br_off_s = {{14{imm16[15]}}, imm16, 2'b00};

  // Candidate next-PC selection.
  always_comb begin
    cand_s = pc_plus4;
    case (npc_op)
      3'b000: cand_s = pc_plus4;
      3'b001: begin
        if (branch_taken) begin
          cand_s = pc_plus4 + br_off_s;
        end else begin
          cand_s = pc_plus4;
        end
      end
      3'b010: cand_s = {pc_r[31:28], instr_index, 2'b00};
      3'b011: cand_s = rs_data;
      default: cand_s = pc_plus4;
    endcase
  end

  assign legal_s = addr_legal(cand_s);

  // Next-state logic: HALT is sticky, stall freezes everything, illegal targets halt.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = cnt_r;
    fault_nxt_s = fault_r;
    case (state_r)
      RUN: begin
        if (stall) begin
          state_nxt_s = RUN;
        end else if (legal_s) begin
          pc_nxt_s  = cand_s;
          cnt_nxt_s = cnt_r + 32'd1;
        end else begin
          state_nxt_s = HALT;
          fault_nxt_s = 1'b1;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = HALT;
        fault_nxt_s = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      pc_r    <= PC_RESET;
      cnt_r   <= 32'd0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

  assign pc          = pc_r;
  assign halted      = (state_r == HALT);
  assign fault       = fault_r;
  assign fetch_count = cnt_r;

endmodule

// File: tb/tb_ifu_npc.sv
// Directed-vector bench for ifu_npc; expected values are hand-computed from the default parameters.
module tb_ifu_npc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'b000;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = 16'h0000;
  logic [25:0] instr_index = 26'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] pc, pc_plus4, pc_plus8, fetch_count;
  logic        halted, fault;

  int checks_s = 0;
  int errors_s = 0;

  ifu_npc dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
    .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4), .pc_plus8(pc_plus8),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s++;
    if (obs !== exp) begin
      errors_s++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    npc_op = 3'b000;
    branch_taken = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_cnt", fetch_count, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_p4", pc_plus4, 32'h3004);
    chk("rst_p8", pc_plus8, 32'h3008);

    // sequential fetch
    npc_op = 3'b000;
    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);
    step(); chk("seq3", pc, 32'h300C);
    chk("seq_cnt", fetch_count, 32'd3);
    chk("seq_p8", pc_plus8, 32'h3014);

    // branches
    do_reset();
    step(); step();
    chk("br_pre", pc, 32'h3008);
    npc_op = 3'b001; branch_taken = 1'b1; imm16 = 16'hFFFE;
    step(); chk("br_taken", pc, 32'h3004);
    npc_op = 3'b000;
    step(); chk("br_mid", pc, 32'h3008);
    npc_op = 3'b001; branch_taken = 1'b0;
    step(); chk("br_not", pc, 32'h300C);
    chk("br_cnt", fetch_count, 32'd5);
    npc_op = 3'b000; branch_taken = 1'b1;
    step(); chk("seq_ignores_bt", pc, 32'h3010);

    // jump and jr
    do_reset();
    npc_op = 3'b010; instr_index = 26'h0000C10;
    step(); chk("jump", pc, 32'h3040);
    npc_op = 3'b011; rs_data = 32'h0000_3100;
    step(); chk("jr", pc, 32'h3100);
    npc_op = 3'b101;
    step(); chk("op5_seq", pc, 32'h3104);
    npc_op = 3'b111;
    step(); chk("op7_seq", pc, 32'h3108);

    // stall
    do_reset();
    npc_op = 3'b000;
    repeat (4) step();
    chk("st_pre", pc, 32'h3010);
    stall = 1'b1; npc_op = 3'b010; instr_index = 26'h0000C10;
    step(); chk("st1_pc", pc, 32'h3010);
    step(); chk("st2_pc", pc, 32'h3010);
    chk("st_cnt", fetch_count, 32'd4);
    npc_op = 3'b011; rs_data = 32'h0000_7000;
    step(); chk("st_nochk", {31'd0, fault}, 32'd0);
    chk("st_nohalt", {31'd0, halted}, 32'd0);
    stall = 1'b0; npc_op = 3'b000;
    step(); chk("st_rel_pc", pc, 32'h3014);
    chk("st_rel_cnt", fetch_count, 32'd5);

    // fault on out-of-range jr, then HALT ignores inputs
    npc_op = 3'b011; rs_data = 32'h0000_7000;
    step();
    chk("flt_pc", pc, 32'h3014);
    chk("flt_halt", {31'd0, halted}, 32'd1);
    chk("flt_fault", {31'd0, fault}, 32'd1);
    chk("flt_cnt", fetch_count, 32'd5);
    rs_data = 32'h0000_3100;
    step(); chk("halt_pc", pc, 32'h3014);
    npc_op = 3'b000; stall = 1'b1;
    step(); chk("halt_pc2", pc, 32'h3014);
    chk("halt_fault", {31'd0, fault}, 32'd1);
    chk("halt_cnt", fetch_count, 32'd5);
    do_reset();
    chk("flt_rst_pc", pc, 32'h3000);
    chk("flt_rst_halt", {31'd0, halted}, 32'd0);
    chk("flt_rst_fault", {31'd0, fault}, 32'd0);
    chk("flt_rst_cnt", fetch_count, 32'd0);

    // misaligned and below-base targets
    npc_op = 3'b011; rs_data = 32'h0000_3002;
    step(); chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", pc, 32'h3000);
    do_reset();
    npc_op = 3'b011; rs_data = 32'h0000_2FFC;
    step(); chk("low_fault", {31'd0, fault}, 32'd1);

    // upper boundary
    do_reset();
    npc_op = 3'b011; rs_data = 32'h0000_6FFC;
    step(); chk("top_pc", pc, 32'h6FFC);
    chk("top_fault", {31'd0, fault}, 32'd0);
    chk("top_cnt", fetch_count, 32'd1);
    npc_op = 3'b000;
    step(); chk("over_pc", pc, 32'h6FFC);
    chk("over_fault", {31'd0, fault}, 32'd1);
    chk("over_halt", {31'd0, halted}, 32'd1);
    chk("over_cnt", fetch_count, 32'd1);

    // reset wins over stall
    stall = 1'b1; reset = 1'b1;
    step(); reset = 1'b0;
    chk("rst_stall_pc", pc, 32'h3000);
    chk("rst_stall_fault", {31'd0, fault}, 32'd0);
    stall = 1'b0; npc_op = 3'b000;
    step(); chk("post_rst", pc, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule

// File: doc/ifu_npc.md
IFU_NPC -- requirements
Module: ifu_npc

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, is the PC value loaded on reset.
REQ-002 Parameter IM_BASE, default 32'h0000_3000, is the lowest legal fetch address.
REQ-003 Parameter IM_WORDS, default 4096, is the instruction-memory depth in words; the highest legal fetch address is IM_BASE+4*IM_WORDS-4 (default 32'h0000_6FFC).
REQ-004 One clock and one reset: reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port stall, input, 1 bit: hold PC this cycle.
REQ-008 Port npc_op, input, 3 bits: next-PC select (000 seq, 001 branch, 010 jump, 011 jump-register).
REQ-009 Port branch_taken, input, 1 bit: branch condition, used only when npc_op=001.
REQ-010 Port imm16, input, 16 bits: branch offset in words.
REQ-011 Port instr_index, input, 26 bits: j/jal target field.
REQ-012 Port rs_data, input, 32 bits: jr target.
REQ-013 Port pc, output, 32 bits: current fetch address, driving the instruction-memory address.
REQ-014 Port pc_plus4, output, 32 bits: combinational pc+4.
REQ-015 Port pc_plus8, output, 32 bits: combinational pc+8, the jal link value.
REQ-016 Port halted, output, 1 bit: fetch stopped.
REQ-017 Port fault, output, 1 bit: the halt was caused by an illegal next-PC.
REQ-018 Port fetch_count, output, 32 bits: number of committed PC updates.

Function
REQ-019 Candidate next-PC is selected by npc_op as follows:
- 000: pc+4.
- 001: pc+4+(sext(imm16)<<2) when branch_taken=1, else pc+4.
- 010: {pc[31:28], instr_index, 2'b00}.
- 011: rs_data.
- 100-111: pc+4.
REQ-020 All target arithmetic is 32-bit modulo 2^32; carries out of bit 31 are discarded.
REQ-021 Two-state FSM, RUN and HALT; reset enters RUN.
REQ-022 In RUN with stall=0 and a legal candidate, pc takes the candidate on the next edge and fetch_count increments by 1.
REQ-023 A candidate is legal iff candidate[1:0]=2'b00 and IM_BASE <= candidate <= IM_BASE+4*IM_WORDS-4 (unsigned).
REQ-024 In RUN with stall=0 and an illegal candidate, on the next edge: pc holds, FSM enters HALT, fault=1, halted=1, fetch_count unchanged.
REQ-025 In RUN with stall=1: pc, fetch_count and state hold, and npc_op, branch_taken, imm16, instr_index and rs_data are ignored (no legality check is made).
REQ-026 In HALT: pc, fetch_count, fault and halted hold regardless of stall or npc_op; only reset leaves HALT.
REQ-027 Priority when events coincide: reset > HALT > stall > update.
REQ-028 fetch_count wraps from 32'hFFFF_FFFF to 0 without affecting any other state.
REQ-029 pc_plus4 and pc_plus8 are combinational from the registered pc, with no added latency.
REQ-030 A branch or jump takes effect with one-cycle latency: the candidate computed in cycle N is visible on pc in cycle N+1.
REQ-031 fault is set only by the REQ-024 transition and never toggles during HALT.

Reset
REQ-032 When reset=1 at a rising edge: pc=PC_RESET, state=RUN, halted=0, fault=0, fetch_count=0.
REQ-033 Reset asserted mid-operation, including during HALT or stall, restores the REQ-032 values on that edge with no residual state.
REQ-034 Outputs are undefined only before the first reset edge; the bench asserts reset for at least 1 cycle before checking.

Verification
REQ-035 Sequential fetch: reset, then npc_op=000 for 3 cycles -> pc 3000, 3004, 3008, 300C; fetch_count=3; pc_plus8=3014.
REQ-036 Branch: pc=3008, npc_op=001, branch_taken=1, imm16=16'hFFFE -> next pc=3004; the same with branch_taken=0 -> next pc=300C.
REQ-037 Jump and jr: pc=3000, npc_op=010, instr_index=26'h0000C10 -> pc=3040; then npc_op=011, rs_data=32'h0000_3100 -> pc=3100.
REQ-038 Stall: pc=3010, stall=1 for 2 cycles with npc_op=010 -> pc stays 3010 and fetch_count is unchanged; after stall=0 with npc_op=000 -> pc=3014.
REQ-039 Fault: npc_op=011 with rs_data=32'h0000_7000 -> pc holds, halted=1, fault=1; all subsequent inputs are ignored; reset -> pc=3000, halted=0, fault=0.
REQ-040 Misalignment and upper boundary:
- rs_data=32'h0000_3002 -> fault.
- rs_data=32'h0000_6FFC -> accepted.
- Sequential step from 6FFC -> fault, with pc held at 6FFC.
